// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the fetch/data memory port arbiter
package MemArbStruct;

  localparam int REQ_AW = 64;
  localparam int REQ_DW = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic [1:0] {NONE, FETCH, DATA} owner_e;

  // Upper bound on port widths: ADDR_WIDTH and DATA_WIDTH must not exceed these.
  typedef struct packed {
    logic              wen;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
    logic [REQ_DW/8-1:0] wmask;
  } request_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of arbitrations fetch has lost
module arb_starve_cnt #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_sat = (r_cnt == CW'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared memory request port
// Data beats fetch unless fetch has lost STARVE_LIMIT arbitrations in a row.
module mem_port_arbiter
  import MemArbStruct::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_stall,
  input  logic                    d_ren,
  input  logic                    d_wen,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_stall,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_wen,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wmask,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);
  localparam int MW = DATA_WIDTH / 8;

  state_e                r_state;
  owner_e                r_owner;
  logic                  r_drop;
  logic                  r_m_valid;
  logic                  r_m_wen;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [DATA_WIDTH-1:0] r_m_wdata;
  logic [MW-1:0]         r_m_wmask;

  logic     w_d_req;
  logic     w_sat;
  logic     w_grant_fetch;
  logic     w_grant_data;
  logic     w_complete;
  logic     w_flush_hit;
  request_t w_req;

  always_comb begin
    w_d_req       = d_ren | d_wen;
    w_grant_fetch = (r_state == IDLE) && if_req && (w_sat || !w_d_req);
    w_grant_data  = (r_state == IDLE) && w_d_req && !(w_sat && if_req);
    w_complete    = !rst && m_rvalid &&
                    ((r_state == WAIT) || ((r_state == ISSUE) && m_ready));
    w_flush_hit   = if_flush && (r_owner == FETCH) && (r_state != IDLE);
    // d_wen wins over d_ren if both are (illegally) set.
    w_req.wen     = d_wen;
    w_req.addr    = REQ_AW'(d_addr);
    w_req.wdata   = REQ_DW'(d_wdata);
    w_req.wmask   = (REQ_DW/8)'(d_wmask);
    if (w_grant_fetch) begin
      w_req.wen   = 1'b0;
      w_req.addr  = REQ_AW'(if_addr);
      w_req.wdata = '0;
      w_req.wmask = '0;
    end
  end

  arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_grant_data && if_req),
    .i_clr (w_grant_fetch),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= NONE;
      r_drop    <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_wen   <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_wmask <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_drop <= 1'b0;
          if (w_grant_fetch || w_grant_data) begin
            r_state   <= ISSUE;
            r_owner   <= w_grant_fetch ? FETCH : DATA;
            r_m_valid <= 1'b1;
            r_m_wen   <= w_req.wen;
            r_m_addr  <= ADDR_WIDTH'(w_req.addr);
            r_m_wdata <= DATA_WIDTH'(w_req.wdata);
            r_m_wmask <= MW'(w_req.wmask);
          end
        end
        ISSUE: begin
          if (w_flush_hit) r_drop <= 1'b1;
          if (m_ready) begin
            r_m_valid <= 1'b0;
            if (m_rvalid) begin
              r_state <= IDLE;
              r_owner <= NONE;
              r_drop  <= 1'b0;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (w_flush_hit) r_drop <= 1'b1;
          if (m_rvalid) begin
            r_state <= IDLE;
            r_owner <= NONE;
            r_drop  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_owner   <= NONE;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_ren && d_wen));

  assign m_valid  = r_m_valid;
  assign m_wen    = r_m_wen;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_wmask  = r_m_wmask;
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;
  // A flush landing on the completion cycle still suppresses delivery.
  assign if_stall = (w_complete && (r_owner == FETCH) && !r_drop && !if_flush) ? 1'b0 : if_req;
  assign d_stall  = (w_complete && (r_owner == DATA)) ? 1'b0 : w_d_req;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import MemArbStruct::*;

  logic        clk, rst;
  logic        if_req, if_flush, if_stall;
  logic [63:0] if_addr, if_rdata;
  logic        d_ren, d_wen, d_stall;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_wmask;
  logic        m_valid, m_ready, m_wen, m_rvalid;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_wmask;

  logic        auto_mode, man_ready, man_rvalid;
  logic [63:0] man_rdata;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } mreq_t;

  mreq_t       q_m[$];
  logic [63:0] q_if[$];
  logic [63:0] q_d[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_valid(m_valid), .m_ready(m_ready), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rd_model(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  // Auto mode: always ready, responds in the issue cycle with rd_model data.
  always_comb begin
    m_ready  = auto_mode ? 1'b1 : man_ready;
    m_rvalid = auto_mode ? m_valid : man_rvalid;
    m_rdata  = auto_mode ? rd_model(m_addr) : man_rdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_m(input logic wen, input logic [63:0] a,
                                 input logic [63:0] w, input logic [7:0] m);
    mreq_t r;
    r.wen = wen; r.addr = a; r.wdata = w; r.wmask = m;
    q_m.push_back(r);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (q_m.size() == 0) chk("m_unexpected", 1, 0);
        else begin
          mreq_t e;
          e = q_m.pop_front();
          chk("m_addr", m_addr, e.addr);
          chk("m_wdata", m_wdata, e.wdata);
          chk("m_wen_wmask", {55'd0, m_wen, m_wmask}, {55'd0, e.wen, e.wmask});
        end
      end
      if (if_req && !if_stall) begin
        if (q_if.size() == 0) chk("if_unexpected", 1, 0);
        else chk("if_rdata", if_rdata, q_if.pop_front());
      end
      if ((d_ren || d_wen) && !d_stall) begin
        if (q_d.size() == 0) chk("d_unexpected", 1, 0);
        else chk("d_rdata", d_rdata, q_d.pop_front());
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_k, f_k, nd;
    logic fdone, saw8;
    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    d_ren = 0; d_wen = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
    auto_mode = 0; man_ready = 0; man_rvalid = 0; man_rdata = 0;
    nxt(); nxt();

    // Reset state
    if_req = 1'b1;
    smp();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_wen", m_wen, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wmask", m_wmask, 0);
    chk("rst_if_stall", if_stall, 1);
    chk("rst_state", dut.r_state, IDLE);
    nxt();
    if_req = 0; rst = 0;
    nxt();

    // Single fetch
    if_req = 1; if_addr = 64'h8000_0000;
    push_m(0, 64'h8000_0000, 0, 0);
    q_if.push_back(64'h0000_0013_0000_0013);
    smp(); chk("f1_c0_m_valid", m_valid, 0); chk("f1_c0_stall", if_stall, 1); nxt();
    smp(); chk("f1_c1_m_valid", m_valid, 1); chk("f1_c1_stall", if_stall, 1); nxt();
    man_ready = 1;
    smp(); chk("f1_c2_m_valid", m_valid, 1); nxt();
    man_ready = 0;
    smp(); chk("f1_c3_m_valid", m_valid, 0); chk("f1_c3_stall", if_stall, 1); nxt();
    man_rvalid = 1; man_rdata = 64'h0000_0013_0000_0013;
    smp(); chk("f1_c4_stall", if_stall, 0); nxt();
    man_rvalid = 0; if_req = 0;
    smp(); chk("f1_c5_m_valid", m_valid, 0); nxt();

    // Store
    d_wen = 1; d_addr = 64'h3000; d_wdata = 64'hDEAD_BEEF; d_wmask = 8'h0F;
    push_m(1, 64'h3000, 64'hDEAD_BEEF, 8'h0F);
    q_d.push_back(64'h0);
    smp(); nxt();
    man_ready = 1;
    smp(); chk("st_m_wen", m_wen, 1); chk("st_m_wmask", m_wmask, 8'h0F); chk("st_c1_stall", d_stall, 1); nxt();
    man_ready = 0;
    smp(); chk("st_c2_stall", d_stall, 1); nxt();
    man_rvalid = 1; man_rdata = 64'h0;
    smp(); chk("st_ack_stall", d_stall, 0); nxt();
    man_rvalid = 0; d_wen = 0; d_wdata = 0; d_wmask = 0;
    nxt();

    // Conflict: data first, fetch after completion plus one bubble
    auto_mode = 1;
    if_req = 1; if_addr = 64'h8000_0040; d_ren = 1; d_addr = 64'h1000;
    push_m(0, 64'h1000, 0, 0);
    push_m(0, 64'h8000_0040, 0, 0);
    q_d.push_back(rd_model(64'h1000));
    q_if.push_back(rd_model(64'h8000_0040));
    d_k = -1; f_k = -1;
    for (int k = 0; k < 20 && (if_req || d_ren); k++) begin
      logic dd, fd;
      smp();
      dd = d_ren && !d_stall;
      fd = if_req && !if_stall;
      if (dd) d_k = k;
      if (fd) f_k = k;
      nxt();
      if (dd) d_ren = 0;
      if (fd) if_req = 0;
    end
    chk("cf_data_done_cycle", 64'(d_k), 1);
    chk("cf_fetch_after_bubble", 64'(f_k - d_k), 2);
    if_req = 0; d_ren = 0;
    nxt();

    // Starvation: fetch wins the 9th arbitration
    if_req = 1; if_addr = 64'h8000_0200; d_ren = 1; d_addr = 64'h2000;
    for (int i = 0; i < 8; i++) begin
      push_m(0, 64'h2000, 0, 0);
      q_d.push_back(rd_model(64'h2000));
    end
    push_m(0, 64'h8000_0200, 0, 0);
    q_if.push_back(rd_model(64'h8000_0200));
    nd = 0; fdone = 0; saw8 = 0;
    for (int k = 0; k < 40 && !fdone; k++) begin
      smp();
      if (d_ren && !d_stall) nd++;
      if (dut.r_state == IDLE && nd == 8 && !saw8) begin
        saw8 = 1;
        chk("sv_cnt_sat", 64'(dut.u_starve.r_cnt), 8);
      end
      if (if_req && !if_stall) begin
        fdone = 1;
        chk("sv_data_grants", 64'(nd), 8);
        chk("sv_cnt_clr", 64'(dut.u_starve.r_cnt), 0);
      end
      nxt();
    end
    chk("sv_fetch_done", 64'(fdone), 1);
    chk("sv_sat_seen", 64'(saw8), 1);
    if_req = 0; d_ren = 0; auto_mode = 0;
    nxt();

    // Flush during WAIT, redirect to a new address
    if_req = 1; if_addr = 64'h8000_0040;
    push_m(0, 64'h8000_0040, 0, 0);
    push_m(0, 64'h8000_0100, 0, 0);
    q_if.push_back(64'h1111_2222_3333_4444);
    nxt();
    man_ready = 1; nxt();
    man_ready = 0; if_flush = 1; if_addr = 64'h8000_0100;
    smp(); chk("fl_wait_state", dut.r_state, WAIT); nxt();
    if_flush = 0; man_rvalid = 1; man_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    smp(); chk("fl_dropped_stall", if_stall, 1); nxt();
    man_rvalid = 0;
    smp(); chk("fl_idle_state", dut.r_state, IDLE); chk("fl_bubble_m_valid", m_valid, 0); nxt();
    man_ready = 1; man_rvalid = 1; man_rdata = 64'h1111_2222_3333_4444;
    smp(); chk("fl_new_m_valid", m_valid, 1); chk("fl_new_stall", if_stall, 0); nxt();
    man_ready = 0; man_rvalid = 0; if_req = 0;
    nxt();

    // Reset mid-WAIT; a late response is ignored
    d_ren = 1; d_addr = 64'h4000;
    push_m(0, 64'h4000, 0, 0);
    nxt();
    man_ready = 1; nxt();
    man_ready = 0; rst = 1;
    smp(); chk("rw_rst_stall", d_stall, 1); nxt();
    rst = 0; man_rvalid = 1; man_rdata = 64'hBAD;
    push_m(0, 64'h4000, 0, 0);
    smp();
    chk("rw_m_valid", m_valid, 0);
    chk("rw_state", dut.r_state, IDLE);
    chk("rw_late_rvalid_stall", d_stall, 1);
    nxt();
    man_ready = 1; man_rvalid = 1; man_rdata = 64'h1234;
    q_d.push_back(64'h1234);
    smp(); chk("rw_retry_stall", d_stall, 0); nxt();
    man_ready = 0; man_rvalid = 0; d_ren = 0;
    nxt(); nxt();

    chk("q_m_empty", 64'(q_m.size()), 0);
    chk("q_if_empty", 64'(q_if.size()), 0);
    chk("q_d_empty", 64'(q_d.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
